// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - op codes, FSM states and op-class helpers for hilo_muldiv
//
// Purpose: shared encodings for the HI/LO unit. The op codes are the
// architectural encodings carried by the execute stage. Codes 11-15 are
// unassigned and behave as NOP.
package hilo_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_t;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// rtl/hilo_muldiv_if.sv - request/response bundle between execute stage and hilo_muldiv
//
// Purpose: groups the HI/LO unit's op request and status signals.
// Signals:
//   start  op request valid this cycle
//   op     4-bit operation code
//   a, b   WIDTH-bit operands
//   flush  abort in-flight division, drop same-cycle start
//   busy   division in progress
//   done   one-cycle pulse after HI/LO was written
//   hilo_o {HI, LO}
// master = execute stage (requester), slave = hilo_muldiv.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [3:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               flush;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] hilo_o;

  modport master (output start, op, a, b, flush, input busy, done, hilo_o);
  modport slave  (input start, op, a, b, flush, output busy, done, hilo_o);
endinterface

// File: rtl/hilo_muldiv_div_iter.sv
// rtl/hilo_muldiv_div_iter.sv - restoring radix-2 divider core on unsigned magnitudes
//
// Purpose: owns the partial remainder, quotient shift register and step
// counter. Sign handling is done by the caller.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture dividend/divisor, clear remainder and counter
//   step                produce one quotient bit (MSB first)
//   abort               discard the in-flight division
//   dividend, divisor   unsigned magnitudes, sampled on load
//   quotient, remainder current result registers
//   last                the next step is the final (WIDTH-th) one
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The remainder stays below the divisor, so the shifted trial value is
  // below 2*divisor and a successful subtraction always fits in WIDTH bits.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    fits    = shifted >= {1'b0, dvs_q};
    diff    = shifted[WIDTH-1:0] - dvs_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (abort) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      rem_q <= fits ? diff : shifted[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], fits};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register with multiply, accumulate, move and iterative divide
//
// Purpose: sole writer of the {HI, LO} pair. MULT/MADD/MSUB/MTHI/MTLO
// complete in one cycle; DIV/DIVU take WIDTH+1 busy cycles.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset, discards any in-flight division
//   bus    hilo_muldiv_if slave: start/op/a/b/flush in, busy/done/hilo_o out
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hilo_muldiv_if.slave bus
);

  localparam int W2 = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [W2-1:0]    hilo_q, hilo_d;
  logic             done_q, done_d;

  // Division context latched at load time for the final fix-up.
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] a_q;

  logic             busy;
  logic             accept;
  logic [W2-1:0]    ext_a, ext_b, prod;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_load, div_step, div_abort, div_last;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic [WIDTH-1:0] fix_lo, fix_hi;

  assign busy   = (state_q != ST_IDLE);
  assign accept = bus.start & ~busy & ~bus.flush;

  // A product truncated to 2*WIDTH bits of sign-extended operands is the
  // exact signed product, so one multiplier serves both signednesses.
  always_comb begin
    ext_a = is_signed(bus.op) ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    ext_b = is_signed(bus.op) ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    prod  = ext_a * ext_b;
  end

  // MIN has magnitude 2^(WIDTH-1), which still fits as an unsigned value.
  always_comb begin
    sign_a = is_signed(bus.op) & bus.a[WIDTH-1];
    sign_b = is_signed(bus.op) & bus.b[WIDTH-1];
    mag_a  = sign_a ? (~bus.a + 1'b1) : bus.a;
    mag_b  = sign_b ? (~bus.b + 1'b1) : bus.b;
  end

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .step      (div_step),
    .abort     (div_abort),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last      (div_last)
  );

  // A zero divisor still runs the full iteration; its result is replaced here.
  always_comb begin
    fix_lo = neg_quo_q ? (~div_quo + 1'b1) : div_quo;
    fix_hi = neg_rem_q ? (~div_rem + 1'b1) : div_rem;
    if (div_zero_q) begin
      fix_lo = '1;
      fix_hi = a_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    hilo_d    = hilo_q;
    done_d    = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;
    div_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_div(bus.op)) begin
            div_load = 1'b1;
            state_d  = ST_RUN;
          end else if (is_mul(bus.op)) begin
            hilo_d = prod;
            done_d = 1'b1;
          end else if (is_acc(bus.op)) begin
            hilo_d = is_sub(bus.op) ? (hilo_q - prod) : (hilo_q + prod);
            done_d = 1'b1;
          end else if (bus.op == OP_MTHI) begin
            hilo_d[W2-1:WIDTH] = bus.a;
            done_d             = 1'b1;
          end else if (bus.op == OP_MTLO) begin
            hilo_d[WIDTH-1:0] = bus.a;
            done_d            = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          div_abort = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          div_step = 1'b1;
          if (div_last) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (bus.flush) begin
          div_abort = 1'b1;
        end else begin
          hilo_d = {fix_hi, fix_lo};
          done_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hilo_q     <= '0;
      done_q     <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_q        <= '0;
    end else begin
      state_q <= state_d;
      hilo_q  <= hilo_d;
      done_q  <= done_d;
      if (div_load) begin
        neg_quo_q  <= sign_a ^ sign_b;
        neg_rem_q  <= sign_a;
        div_zero_q <= (bus.b == '0);
        a_q        <= bus.a;
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done_q;
  assign bus.hilo_o = hilo_q;

endmodule
